// File: rtl/fg_vram_arbiter_if.sv
// Signal bundle between the 68000 bus decode, the video tile fetcher, the foreground
// tile RAM and fg_vram_arbiter.
interface fg_vram_arbiter_if #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 16
);
  logic          cpu_cs;
  logic          cpu_rw;
  logic          cpu_uds_n;
  logic          cpu_lds_n;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic [DW-1:0] cpu_dout;
  logic          cpu_dtack_n;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic [DW-1:0] vid_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [1:0]    ram_we;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  cpu_cs, cpu_rw, cpu_uds_n, cpu_lds_n, cpu_addr, cpu_din,
    input  vid_req, vid_addr, ram_dout,
    output cpu_dout, cpu_dtack_n, vid_ack, vid_data, ram_addr, ram_din, ram_we
  );

  modport master (
    output cpu_cs, cpu_rw, cpu_uds_n, cpu_lds_n, cpu_addr, cpu_din,
    output vid_req, vid_addr, ram_dout,
    input  cpu_dout, cpu_dtack_n, vid_ack, vid_data, ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/fg_vram_arbiter.sv
// Foreground tile RAM arbiter: serialises 68000 and video fetch accesses, drives DTACK.
// Define FG_VRAM_ARB_VIDEO_PRIORITY_EN to make video win every tie instead of alternating.
module fg_vram_arbiter #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 16
) (
  input logic              clk,
  input logic              reset,
  fg_vram_arbiter_if.slave io_bus
);

  typedef enum logic [1:0] {StIdle, StAcc, StDone, StHold} state_e;
  typedef enum logic {OwnCpu = 1'b0, OwnVid = 1'b1} owner_e;

  state_e        r_state, w_state;
  owner_e        r_owner, w_owner;
  owner_e        r_last_grant, w_last_grant;
  logic          r_cpu_rd, w_cpu_rd;
  logic [AW-1:0] r_ram_addr, w_ram_addr;
  logic [DW-1:0] r_ram_din, w_ram_din;
  logic [1:0]    r_ram_we, w_ram_we;
  logic [DW-1:0] r_cpu_dout, w_cpu_dout;
  logic          r_cpu_dtack_n, w_cpu_dtack_n;
  logic          r_vid_ack, w_vid_ack;
  logic [DW-1:0] r_vid_data, w_vid_data;

  logic w_cpu_pend, w_vid_pend, w_grant_vid;

  // A request in its ack cycle is already served; masking it avoids a double fetch.
  assign w_cpu_pend = io_bus.cpu_cs;
  assign w_vid_pend = io_bus.vid_req & ~r_vid_ack;

`ifdef FG_VRAM_ARB_VIDEO_PRIORITY_EN
  assign w_grant_vid = w_vid_pend;
`else
  assign w_grant_vid = w_vid_pend & (~w_cpu_pend | (r_last_grant == OwnCpu));
`endif

  always_comb begin
    w_state       = r_state;
    w_owner       = r_owner;
    w_last_grant  = r_last_grant;
    w_cpu_rd      = r_cpu_rd;
    w_ram_addr    = r_ram_addr;
    w_ram_din     = r_ram_din;
    w_ram_we      = 2'b00;
    w_cpu_dout    = r_cpu_dout;
    w_cpu_dtack_n = r_cpu_dtack_n;
    w_vid_ack     = 1'b0;
    w_vid_data    = r_vid_data;
    unique case (r_state)
      StIdle: begin
        if (w_cpu_pend || w_vid_pend) begin
          w_state = StAcc;
          if (w_grant_vid) begin
            w_owner      = OwnVid;
            w_last_grant = OwnVid;
            w_ram_addr   = io_bus.vid_addr;
          end else begin
            w_owner      = OwnCpu;
            w_last_grant = OwnCpu;
            w_ram_addr   = io_bus.cpu_addr;
            w_cpu_rd     = io_bus.cpu_rw;
            if (!io_bus.cpu_rw) begin
              w_ram_din = io_bus.cpu_din;
              w_ram_we  = {~io_bus.cpu_uds_n, ~io_bus.cpu_lds_n};
            end
          end
        end
      end
      StAcc: w_state = StDone;
      StDone: begin
        if (r_owner == OwnVid) begin
          w_vid_data = io_bus.ram_dout;
          w_vid_ack  = 1'b1;
          w_state    = StIdle;
        end else begin
          if (r_cpu_rd) w_cpu_dout = io_bus.ram_dout;
          w_cpu_dtack_n = 1'b0;
          w_state       = StHold;
        end
      end
      // DTACK stays low until the 68000 ends the bus cycle; video waits meanwhile.
      StHold: begin
        if (!io_bus.cpu_cs) begin
          w_cpu_dtack_n = 1'b1;
          w_state       = StIdle;
        end
      end
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_owner       <= OwnCpu;
      r_last_grant  <= OwnCpu;
      r_cpu_rd      <= 1'b1;
      r_ram_addr    <= '0;
      r_ram_din     <= '0;
      r_ram_we      <= 2'b00;
      r_cpu_dout    <= '0;
      r_cpu_dtack_n <= 1'b1;
      r_vid_ack     <= 1'b0;
      r_vid_data    <= '0;
    end else begin
      r_state       <= w_state;
      r_owner       <= w_owner;
      r_last_grant  <= w_last_grant;
      r_cpu_rd      <= w_cpu_rd;
      r_ram_addr    <= w_ram_addr;
      r_ram_din     <= w_ram_din;
      r_ram_we      <= w_ram_we;
      r_cpu_dout    <= w_cpu_dout;
      r_cpu_dtack_n <= w_cpu_dtack_n;
      r_vid_ack     <= w_vid_ack;
      r_vid_data    <= w_vid_data;
    end
  end

  assign io_bus.cpu_dout    = r_cpu_dout;
  assign io_bus.cpu_dtack_n = r_cpu_dtack_n;
  assign io_bus.vid_ack     = r_vid_ack;
  assign io_bus.vid_data    = r_vid_data;
  assign io_bus.ram_addr    = r_ram_addr;
  assign io_bus.ram_din     = r_ram_din;
  assign io_bus.ram_we      = r_ram_we;

endmodule

// File: tb/tb_fg_vram_arbiter.sv
// Scoreboard bench for fg_vram_arbiter with a behavioural 1-cycle-latency byte-write RAM.
module tb_fg_vram_arbiter;
  localparam int unsigned AW = 11;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;

  fg_vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  fg_vram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model, preloaded on the first reset edge
  logic [15:0] mem [0:2047];
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (reset && !loaded) begin
      mem[11'h123] <= 16'hBEEF;
      mem[11'h010] <= 16'hFFFF;
      mem[11'h020] <= 16'h0F0F;
      mem[11'h030] <= 16'h3C3C;
      mem[11'h040] <= 16'h4444;
      mem[11'h7FF] <= 16'h0000;
      loaded       <= 1'b1;
    end else begin
      if (bus.ram_we[1]) mem[bus.ram_addr][15:8] <= bus.ram_din[15:8];
      if (bus.ram_we[0]) mem[bus.ram_addr][7:0]  <= bus.ram_din[7:0];
    end
    bus.ram_dout <= mem[bus.ram_addr];
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [15:0] data;
    logic [31:0] cyc;
  } rsp_t;

  typedef struct packed {
    logic [10:0] addr;
    logic [15:0] din;
    logic [1:0]  we;
    logic [31:0] cyc;
  } wr_t;

  rsp_t vq[$];
  rsp_t cq[$];
  wr_t  wq[$];

  // Monitor: pops expectations whenever the DUT presents a response or a write
  rsp_t mv, mc;
  wr_t  mw;
  logic prev_dtack_n = 1'b1;
  always @(negedge clk) begin
    if (cyc != 0) begin
      if (bus.vid_ack) begin
        if (vq.size() == 0) check("vid_ack_unexpected", 32'd1, 32'd0);
        else begin
          mv = vq.pop_front();
          check("vid_data", 32'(bus.vid_data), 32'(mv.data));
          check("vid_ack_cycle", cyc, mv.cyc);
        end
      end
      if (!bus.cpu_dtack_n && prev_dtack_n) begin
        if (cq.size() == 0) check("dtack_unexpected", 32'd1, 32'd0);
        else begin
          mc = cq.pop_front();
          check("cpu_dout", 32'(bus.cpu_dout), 32'(mc.data));
          check("dtack_cycle", cyc, mc.cyc);
        end
      end
      if (bus.ram_we != 2'b00) begin
        if (wq.size() == 0) check("ram_we_unexpected", 32'(bus.ram_we), 32'd0);
        else begin
          mw = wq.pop_front();
          check("ram_addr", 32'(bus.ram_addr), 32'(mw.addr));
          check("ram_din", 32'(bus.ram_din), 32'(mw.din));
          check("ram_we", 32'(bus.ram_we), 32'(mw.we));
          check("ram_we_cycle", cyc, mw.cyc);
        end
      end
    end
    prev_dtack_n = bus.cpu_dtack_n;
  end

  task automatic vid_fetch(input logic [10:0] a, input logic [15:0] exp, input int lat);
    bit seen;
    @(posedge clk); #1;
    vq.push_back('{data: exp, cyc: cyc + 32'(lat)});
    bus.vid_addr = a;
    bus.vid_req  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = bus.vid_ack;
    end
    if (!seen) check("vid_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.vid_req = 1'b0;
  endtask

  task automatic cpu_access(input logic rw, input logic [10:0] a, input logic [15:0] d,
                            input logic uds_n, input logic lds_n,
                            input logic [15:0] exp_dout, input int lat);
    bit seen;
    @(posedge clk); #1;
    cq.push_back('{data: exp_dout, cyc: cyc + 32'(lat)});
    if (!rw && (!uds_n || !lds_n))
      wq.push_back('{addr: a, din: d, we: {~uds_n, ~lds_n}, cyc: cyc + 32'(lat) - 2});
    bus.cpu_rw    = rw;
    bus.cpu_addr  = a;
    bus.cpu_din   = d;
    bus.cpu_uds_n = uds_n;
    bus.cpu_lds_n = lds_n;
    bus.cpu_cs    = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = !bus.cpu_dtack_n;
    end
    if (!seen) check("dtack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.cpu_cs = 1'b0;
    @(negedge clk);
    check("dtack_hold", 32'(bus.cpu_dtack_n), 32'd0);
    @(negedge clk);
    check("dtack_release", 32'(bus.cpu_dtack_n), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cpu_cs    = 1'b0;
    bus.cpu_rw    = 1'b1;
    bus.cpu_uds_n = 1'b1;
    bus.cpu_lds_n = 1'b1;
    bus.cpu_addr  = '0;
    bus.cpu_din   = '0;
    bus.vid_req   = 1'b0;
    bus.vid_addr  = '0;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dtack_n", 32'(bus.cpu_dtack_n), 32'd1);
    check("rst_vid_ack", 32'(bus.vid_ack), 32'd0);
    check("rst_ram_we", 32'(bus.ram_we), 32'd0);
    check("rst_cpu_dout", 32'(bus.cpu_dout), 32'd0);
    check("rst_vid_data", 32'(bus.vid_data), 32'd0);
    check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    check("rst_ram_din", 32'(bus.ram_din), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    vid_fetch(11'h123, 16'hBEEF, 3);
    cpu_access(1'b0, 11'h010, 16'hA55A, 1'b0, 1'b1, 16'h0000, 3);
    cpu_access(1'b1, 11'h010, 16'h0000, 1'b0, 1'b0, 16'hA5FF, 3);
    cpu_access(1'b0, 11'h010, 16'h1177, 1'b1, 1'b0, 16'hA5FF, 3);
    cpu_access(1'b1, 11'h010, 16'h0000, 1'b0, 1'b0, 16'hA577, 3);
    // Both strobes inactive: no RAM write, but the cycle still acks
    cpu_access(1'b0, 11'h040, 16'hDEAD, 1'b1, 1'b1, 16'hA577, 3);
    cpu_access(1'b1, 11'h040, 16'h0000, 1'b0, 1'b0, 16'h4444, 3);

    // Tie with last grant CPU: video first, CPU pays one access
    fork
      vid_fetch(11'h123, 16'hBEEF, 3);
      cpu_access(1'b1, 11'h030, 16'h0000, 1'b0, 1'b0, 16'h3C3C, 6);
    join
    vid_fetch(11'h020, 16'h0F0F, 3);
`ifdef FG_VRAM_ARB_VIDEO_PRIORITY_EN
    fork
      vid_fetch(11'h020, 16'h0F0F, 3);
      cpu_access(1'b1, 11'h010, 16'h0000, 1'b0, 1'b0, 16'hA577, 6);
    join
`else
    // Last grant video: CPU first; video also waits out the DTACK hold
    fork
      vid_fetch(11'h020, 16'h0F0F, 8);
      cpu_access(1'b1, 11'h010, 16'h0000, 1'b0, 1'b0, 16'hA577, 3);
    join
`endif

    // One-cycle cs pulse on a write; later bus changes must be ignored
    @(posedge clk); #1;
    cq.push_back('{data: 16'hA577, cyc: cyc + 3});
    wq.push_back('{addr: 11'h7FF, din: 16'h1234, we: 2'b11, cyc: cyc + 1});
    bus.cpu_rw    = 1'b0;
    bus.cpu_addr  = 11'h7FF;
    bus.cpu_din   = 16'h1234;
    bus.cpu_uds_n = 1'b0;
    bus.cpu_lds_n = 1'b0;
    bus.cpu_cs    = 1'b1;
    @(posedge clk); #1;
    bus.cpu_cs   = 1'b0;
    bus.cpu_rw   = 1'b1;
    bus.cpu_addr = 11'h000;
    bus.cpu_din  = 16'h0000;
    repeat (3) @(negedge clk);
    check("abort_dtack_low", 32'(bus.cpu_dtack_n), 32'd0);
    @(negedge clk);
    check("abort_dtack_high", 32'(bus.cpu_dtack_n), 32'd1);
    cpu_access(1'b1, 11'h7FF, 16'h0000, 1'b0, 1'b0, 16'h1234, 3);

    // Reset during the ACC cycle of a CPU write
    @(posedge clk); #1;
    wq.push_back('{addr: 11'h050, din: 16'hBBBB, we: 2'b11, cyc: cyc + 1});
    bus.cpu_rw    = 1'b0;
    bus.cpu_addr  = 11'h050;
    bus.cpu_din   = 16'hBBBB;
    bus.cpu_uds_n = 1'b0;
    bus.cpu_lds_n = 1'b0;
    bus.cpu_cs    = 1'b1;
    @(posedge clk); #1;
    reset      = 1'b1;
    bus.cpu_cs = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rstacc_ram_we", 32'(bus.ram_we), 32'd0);
    check("rstacc_dtack_n", 32'(bus.cpu_dtack_n), 32'd1);
    check("rstacc_vid_ack", 32'(bus.vid_ack), 32'd0);
    check("rstacc_cpu_dout", 32'(bus.cpu_dout), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstacc_dtack_idle", 32'(bus.cpu_dtack_n), 32'd1);
    cpu_access(1'b1, 11'h123, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 3);

    repeat (5) @(posedge clk);
    check("vid_queue_drained", 32'(vq.size()), 32'd0);
    check("cpu_queue_drained", 32'(cq.size()), 32'd0);
    check("wr_queue_drained", 32'(wq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
